// File: rtl/pixel_pipeline_pkg.sv
// Shared types for the pixel pipeline.
//   z_func_e   : depth compare function codes (RENDER_MODE.Z_FUNC encoding)
//   ez_state_e : early-Z stage control states
//   sat_inc    : saturating increment for the 16-bit event counters
package pixel_pipeline_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 640;
  localparam int unsigned COORD_W_DEF   = 10;
  localparam int unsigned Z_W_DEF       = 16;
  localparam int unsigned ADDR_W_DEF    = 19;
  localparam int unsigned PAYLOAD_W_DEF = 64;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [2:0] {
    Z_NEVER    = 3'd0,
    Z_LESS     = 3'd1,
    Z_EQUAL    = 3'd2,
    Z_LEQUAL   = 3'd3,
    Z_GREATER  = 3'd4,
    Z_NOTEQUAL = 3'd5,
    Z_GEQUAL   = 3'd6,
    Z_ALWAYS   = 3'd7
  } z_func_e;

  typedef enum logic [2:0] {
    EZ_IDLE    = 3'd0,
    EZ_RD_REQ  = 3'd1,
    EZ_RD_WAIT = 3'd2,
    EZ_WRITE   = 3'd3,
    EZ_OUT     = 3'd4
  } ez_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/z_compare.sv
// Combinational depth comparator, shared by the early-Z and late-Z paths.
//   func  : compare function
//   z_new : incoming fragment depth
//   z_old : depth currently stored in the Z-buffer
//   pass  : 1 when the fragment survives (unsigned compare of z_new vs z_old)
module z_compare
  import pixel_pipeline_pkg::*;
#(
  parameter int unsigned Z_W = Z_W_DEF
) (
  input  z_func_e        func,
  input  logic [Z_W-1:0] z_new,
  input  logic [Z_W-1:0] z_old,
  output logic           pass
);

  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // pass, so no latch is inferred even if a branch is forgotten.
    pass = 1'b0;
    unique case (func)
      Z_NEVER:    pass = 1'b0;
      Z_LESS:     pass = (z_new <  z_old);
      Z_EQUAL:    pass = (z_new == z_old);
      Z_LEQUAL:   pass = (z_new <= z_old);
      Z_GREATER:  pass = (z_new >  z_old);
      Z_NOTEQUAL: pass = (z_new != z_old);
      Z_GEQUAL:   pass = (z_new >= z_old);
      Z_ALWAYS:   pass = 1'b1;
      default:    pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/early_z_test.sv
// Early depth-test stage of the pixel pipeline.
// Takes one fragment at a time together with its stipple discard flag.
// Stipple-killed fragments vanish without touching the Z-buffer. Otherwise
// the stored depth is read, compared, optionally rewritten, and surviving
// fragments are handed downstream.
//   clk, rst                      : clock, synchronous active-high reset
//   in_*                          : upstream fragment + valid/ready
//   z_test_en, z_write_en, z_func : render-mode depth controls
//   zb_rd_*                       : Z-buffer read address/data channel
//   zb_wr_*                       : Z-buffer write channel
//   out_*                         : downstream fragment + valid/ready
//   cnt_stipple_kill, cnt_z_kill  : saturating discard counters
module early_z_test
  import pixel_pipeline_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned Z_W       = Z_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [Z_W-1:0]       in_z,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_discard,
  input  logic                 z_test_en,
  input  logic                 z_write_en,
  input  logic [2:0]           z_func,
  output logic                 zb_rd_req,
  input  logic                 zb_rd_ready,
  output logic [ADDR_W-1:0]    zb_rd_addr,
  input  logic                 zb_rd_valid,
  input  logic [Z_W-1:0]       zb_rd_data,
  output logic                 zb_wr_req,
  input  logic                 zb_wr_ready,
  output logic [ADDR_W-1:0]    zb_wr_addr,
  output logic [Z_W-1:0]       zb_wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic [Z_W-1:0]       out_z,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     cnt_stipple_kill,
  output logic [CNT_W-1:0]     cnt_z_kill
);

  ez_state_e              state_q, state_d;
  logic [COORD_W-1:0]     x_q, x_d;
  logic [COORD_W-1:0]     y_q, y_d;
  logic [Z_W-1:0]         z_q, z_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   test_en_q, test_en_d;
  logic                   write_en_q, write_en_d;
  z_func_e                func_q, func_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]       stip_cnt_q, stip_cnt_d;
  logic [CNT_W-1:0]       zkill_cnt_q, zkill_cnt_d;

  z_func_e                in_func;
  logic [ADDR_W-1:0]      in_addr;
  logic                   accept;
  logic                   depth_pass;

  assign in_func = z_func_e'(z_func);
  assign accept  = in_valid && (state_q == EZ_IDLE);

  // Row-major address; the products are deliberately truncated to ADDR_W.
  assign in_addr = ADDR_W'(in_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(in_x);

  z_compare #(.Z_W(Z_W)) u_z_compare (
    .func  (func_q),
    .z_new (z_q),
    .z_old (zb_rd_data),
    .pass  (depth_pass)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    payload_d   = payload_q;
    test_en_d   = test_en_q;
    write_en_d  = write_en_q;
    func_d      = func_q;
    addr_d      = addr_q;
    stip_cnt_d  = stip_cnt_q;
    zkill_cnt_d = zkill_cnt_q;

    unique case (state_q)
      EZ_IDLE: begin
        if (accept) begin
          x_d        = in_x;
          y_d        = in_y;
          z_d        = in_z;
          payload_d  = in_payload;
          test_en_d  = z_test_en;
          write_en_d = z_write_en;
          func_d     = in_func;
          addr_d     = in_addr;
          if (in_discard) begin
            stip_cnt_d = sat_inc(stip_cnt_q);
          end else if (!z_test_en || in_func == Z_ALWAYS) begin
            // Depth writes are only honoured while testing is enabled.
            state_d = (z_write_en && z_test_en) ? EZ_WRITE : EZ_OUT;
          end else if (in_func == Z_NEVER) begin
            zkill_cnt_d = sat_inc(zkill_cnt_q);
          end else begin
            state_d = EZ_RD_REQ;
          end
        end
      end
      EZ_RD_REQ: begin
        if (zb_rd_ready) state_d = EZ_RD_WAIT;
      end
      EZ_RD_WAIT: begin
        // Read data is only meaningful here; strobes in other states are dropped.
        if (zb_rd_valid) begin
          if (depth_pass) begin
            state_d = (write_en_q && test_en_q) ? EZ_WRITE : EZ_OUT;
          end else begin
            zkill_cnt_d = sat_inc(zkill_cnt_q);
            state_d     = EZ_IDLE;
          end
        end
      end
      EZ_WRITE: begin
        if (zb_wr_ready) state_d = EZ_OUT;
      end
      EZ_OUT: begin
        if (out_ready) state_d = EZ_IDLE;
      end
      default: state_d = EZ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the fragment registers are reset too, so outputs come up as
    // zeros rather than X and a reset mid-flight leaves no stale fragment.
    if (rst) begin
      state_q     <= EZ_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      payload_q   <= '0;
      test_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      func_q      <= Z_NEVER;
      addr_q      <= '0;
      stip_cnt_q  <= '0;
      zkill_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its _d, independent of statement order.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      payload_q   <= payload_d;
      test_en_q   <= test_en_d;
      write_en_q  <= write_en_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      stip_cnt_q  <= stip_cnt_d;
      zkill_cnt_q <= zkill_cnt_d;
    end
  end

  // All handshake outputs are decoded from the registered state only.
  assign in_ready         = (state_q == EZ_IDLE);
  assign zb_rd_req        = (state_q == EZ_RD_REQ);
  assign zb_wr_req        = (state_q == EZ_WRITE);
  assign out_valid        = (state_q == EZ_OUT);
  assign zb_rd_addr       = addr_q;
  assign zb_wr_addr       = addr_q;
  assign zb_wr_data       = z_q;
  assign out_x            = x_q;
  assign out_y            = y_q;
  assign out_z            = z_q;
  assign out_payload      = payload_q;
  assign cnt_stipple_kill = stip_cnt_q;
  assign cnt_z_kill       = zkill_cnt_q;

endmodule

// File: tb/tb_early_z_test.sv
// Directed bench for early_z_test: a vector table of single fragments run
// against a bench-side Z-buffer model, followed by hand-written sequences
// for back-to-back ordering with a stalled write and reset during a read.
module tb_early_z_test;
  import pixel_pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [9:0]  in_x, in_y;
  logic [15:0] in_z;
  logic [63:0] in_payload;
  logic        in_discard, z_test_en, z_write_en;
  logic [2:0]  z_func;
  logic        zb_rd_req, zb_rd_ready, zb_rd_valid;
  logic [18:0] zb_rd_addr;
  logic [15:0] zb_rd_data;
  logic        zb_wr_req, zb_wr_ready;
  logic [18:0] zb_wr_addr;
  logic [15:0] zb_wr_data;
  logic        out_valid, out_ready;
  logic [9:0]  out_x, out_y;
  logic [15:0] out_z;
  logic [63:0] out_payload;
  logic [15:0] cnt_stipple_kill, cnt_z_kill;

  early_z_test dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_z(in_z), .in_payload(in_payload), .in_discard(in_discard),
    .z_test_en(z_test_en), .z_write_en(z_write_en), .z_func(z_func),
    .zb_rd_req(zb_rd_req), .zb_rd_ready(zb_rd_ready), .zb_rd_addr(zb_rd_addr),
    .zb_rd_valid(zb_rd_valid), .zb_rd_data(zb_rd_data),
    .zb_wr_req(zb_wr_req), .zb_wr_ready(zb_wr_ready), .zb_wr_addr(zb_wr_addr),
    .zb_wr_data(zb_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_payload(out_payload),
    .cnt_stipple_kill(cnt_stipple_kill), .cnt_z_kill(cnt_z_kill)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Z-buffer model / event logger ----------------
  logic [15:0] zmem [0:524287];
  int          rd_lat   = 1;
  int          wr_stall = 0;
  int          rd_pend  = 0;
  int          wr_wait  = 0;
  logic [15:0] rd_hold;
  int          rd_q[$], wr_q[$], out_q[$];
  logic [18:0] last_rd_addr, last_wr_addr;
  logic [15:0] last_wr_data;
  logic [9:0]  last_out_x, last_out_y;
  logic [15:0] last_out_z;
  logic [63:0] last_out_payload;

  // All DUT handshake outputs are Moore, so at the falling edge they are
  // final; values recorded here describe the handshake at the next rise.
  initial begin
    zb_rd_ready = 1'b0; zb_rd_valid = 1'b0; zb_rd_data = '0; zb_wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      zb_rd_valid = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          zb_rd_valid = 1'b1;
          zb_rd_data  = rd_hold;
        end
      end
      if (zb_wr_req) begin
        if (wr_wait >= wr_stall) zb_wr_ready = 1'b1;
        else begin zb_wr_ready = 1'b0; wr_wait++; end
      end else begin
        zb_wr_ready = 1'b0;
      end
      zb_rd_ready = 1'b1;
      if (zb_rd_req && zb_rd_ready) begin
        rd_q.push_back(cyc + 1);
        last_rd_addr = zb_rd_addr;
        rd_hold      = zmem[zb_rd_addr];
        rd_pend      = rd_lat;
      end
      if (zb_wr_req && zb_wr_ready) begin
        wr_q.push_back(cyc + 1);
        zmem[zb_wr_addr] = zb_wr_data;
        last_wr_addr = zb_wr_addr;
        last_wr_data = zb_wr_data;
        wr_wait = 0;
      end
      if (out_valid && out_ready) begin
        out_q.push_back(cyc + 1);
        last_out_x = out_x; last_out_y = out_y;
        last_out_z = out_z; last_out_payload = out_payload;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frag(input logic [9:0] x, input logic [9:0] y, input logic [15:0] z,
                           input logic [63:0] pl, input logic disc, input logic ten,
                           input logic wen, input logic [2:0] fn,
                           output int acc, output logic rdy_after);
    int n;
    @(negedge clk);
    in_x = x; in_y = y; in_z = z; in_payload = pl; in_discard = disc;
    z_test_en = ten; z_write_en = wen; z_func = fn; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    acc = cyc + 1;
    @(negedge clk);
    in_valid  = 1'b0;
    rdy_after = in_ready;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #2;
    while (!(in_ready && rd_pend == 0) && n < 100) begin @(posedge clk); #2; n++; end
    if (!in_ready) check("idle_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); out_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        disc, ten, wen;
    logic [2:0]  fn;
    logic [9:0]  x, y;
    logic [15:0] z, stored;
    logic [18:0] addr;
    logic        exp_rd, exp_wr, exp_out, exp_rdy;
    int          exp_lat;
    logic [15:0] exp_sk, exp_zk;
  } vec_t;

  function automatic vec_t mk(input int disc, input int ten, input int wen, input z_func_e fn,
                              input int x, input int y, input int z, input int st, input int addr,
                              input int rd, input int wr, input int o, input int rdy,
                              input int lat, input int sk, input int zk);
    vec_t v;
    v.disc = disc[0]; v.ten = ten[0]; v.wen = wen[0]; v.fn = fn;
    v.x = x[9:0]; v.y = y[9:0]; v.z = z[15:0]; v.stored = st[15:0]; v.addr = addr[18:0];
    v.exp_rd = rd[0]; v.exp_wr = wr[0]; v.exp_out = o[0]; v.exp_rdy = rdy[0];
    v.exp_lat = lat; v.exp_sk = sk[15:0]; v.exp_zk = zk[15:0];
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int          acc;
    logic        rdy;
    logic [63:0] pl;
    int          wr_before;

    //               dis ten wen func        x    y    z       stored  addr    rd wr o rdy lat sk zk
    vecs[0]  = mk(1, 1, 1, Z_LESS,     3,    4,    16'h1111, 16'h0000, 2563,   0, 0, 0, 1, 0, 1, 0);
    vecs[1]  = mk(0, 0, 1, Z_LESS,     5,    2,    16'h1234, 16'h2000, 1285,   0, 0, 1, 0, 1, 1, 0);
    vecs[2]  = mk(0, 1, 1, Z_LESS,     5,    2,    16'h1000, 16'h2000, 1285,   1, 1, 1, 0, 4, 1, 0);
    vecs[3]  = mk(0, 1, 1, Z_LESS,     10,   3,    16'h3000, 16'h2000, 1930,   1, 0, 0, 0, 0, 1, 1);
    vecs[4]  = mk(0, 1, 1, Z_NEVER,    0,    1,    16'h0001, 16'h0005, 640,    0, 0, 0, 1, 0, 1, 2);
    vecs[5]  = mk(0, 1, 1, Z_ALWAYS,   0,    0,    16'h0042, 16'hFFFF, 0,      0, 1, 1, 0, 2, 1, 2);
    vecs[6]  = mk(0, 1, 1, Z_GREATER,  1,    0,    16'h0100, 16'h0100, 1,      1, 0, 0, 0, 0, 1, 3);
    vecs[7]  = mk(0, 1, 0, Z_GEQUAL,   1,    0,    16'h0100, 16'h0100, 1,      1, 0, 1, 0, 3, 1, 3);
    vecs[8]  = mk(0, 1, 1, Z_EQUAL,    2,    0,    16'h5555, 16'h5555, 2,      1, 1, 1, 0, 4, 1, 3);
    vecs[9]  = mk(0, 1, 1, Z_NOTEQUAL, 3,    0,    16'h7777, 16'h7777, 3,      1, 0, 0, 0, 0, 1, 4);
    vecs[10] = mk(0, 0, 1, Z_NEVER,    6,    6,    16'h2222, 16'h3333, 3846,   0, 0, 1, 0, 1, 1, 4);
    vecs[11] = mk(0, 1, 1, Z_LEQUAL,   4,    0,    16'hFFFF, 16'hFFFF, 4,      1, 1, 1, 0, 4, 1, 4);
    vecs[12] = mk(0, 1, 1, Z_LESS,     5,    0,    16'h8000, 16'h7FFF, 5,      1, 0, 0, 0, 0, 1, 5);
    vecs[13] = mk(0, 1, 1, Z_ALWAYS,   1023, 1023, 16'h0ABC, 16'h0000, 131455, 0, 1, 1, 0, 2, 1, 5);
    vecs[14] = mk(0, 1, 0, Z_GREATER,  8,    1,    16'h8000, 16'h7FFF, 648,    1, 0, 1, 0, 3, 1, 5);
    vecs[15] = mk(0, 0, 1, Z_ALWAYS,   2,    1,    16'h4444, 16'h9999, 642,    0, 0, 1, 0, 1, 1, 5);

    for (int i = 0; i < 524288; i++) zmem[i] = 16'h0000;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_payload = '0;
    in_discard = 1'b0; z_test_en = 1'b0; z_write_en = 1'b0; z_func = 3'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;

    // Reset state
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_rd_req",    {63'd0, zb_rd_req}, 64'd0);
    check("rst_wr_req",    {63'd0, zb_wr_req}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_cnt_stip",  64'(cnt_stipple_kill), 64'd0);
    check("rst_cnt_z",     64'(cnt_z_kill), 64'd0);
    check("rst_out_payload", out_payload, 64'd0);
    check("rst_rd_addr",   64'(zb_rd_addr), 64'd0);

    // Table-driven single fragments
    for (int i = 0; i < 16; i++) begin
      zmem[vecs[i].addr] = vecs[i].stored;
      clear_logs();
      pl = {48'hA5A5_5A5A_C3C3, 16'(i)};
      send_frag(vecs[i].x, vecs[i].y, vecs[i].z, pl, vecs[i].disc, vecs[i].ten,
                vecs[i].wen, vecs[i].fn, acc, rdy);
      wait_idle();
      check($sformatf("v%0d_ready_next", i), {63'd0, rdy}, {63'd0, vecs[i].exp_rdy});
      check($sformatf("v%0d_reads", i), 64'(rd_q.size()), {63'd0, vecs[i].exp_rd});
      check($sformatf("v%0d_writes", i), 64'(wr_q.size()), {63'd0, vecs[i].exp_wr});
      check($sformatf("v%0d_outs", i), 64'(out_q.size()), {63'd0, vecs[i].exp_out});
      if (vecs[i].exp_rd && rd_q.size() > 0)
        check($sformatf("v%0d_rd_addr", i), 64'(last_rd_addr), 64'(vecs[i].addr));
      if (vecs[i].exp_wr && wr_q.size() > 0) begin
        check($sformatf("v%0d_wr_addr", i), 64'(last_wr_addr), 64'(vecs[i].addr));
        check($sformatf("v%0d_wr_data", i), 64'(last_wr_data), 64'(vecs[i].z));
      end
      if (vecs[i].exp_out && out_q.size() > 0) begin
        check($sformatf("v%0d_out_x", i), 64'(last_out_x), 64'(vecs[i].x));
        check($sformatf("v%0d_out_y", i), 64'(last_out_y), 64'(vecs[i].y));
        check($sformatf("v%0d_out_z", i), 64'(last_out_z), 64'(vecs[i].z));
        check($sformatf("v%0d_out_payload", i), last_out_payload, pl);
        check($sformatf("v%0d_latency", i), 64'(out_q[0] - acc), 64'(vecs[i].exp_lat));
      end
      check($sformatf("v%0d_cnt_stip", i), 64'(cnt_stipple_kill), 64'(vecs[i].exp_sk));
      check($sformatf("v%0d_cnt_z", i), 64'(cnt_z_kill), 64'(vecs[i].exp_zk));
    end

    // Back-to-back same pixel, write stalled 4 cycles: the second read must
    // see the first fragment's depth (0x0400), so 0x0600 LEQUAL fails.
    zmem[4487] = 16'h0800;
    wr_stall = 4;
    clear_logs();
    send_frag(10'd7, 10'd7, 16'h0400, 64'h1, 1'b0, 1'b1, 1'b1, Z_LEQUAL, acc, rdy);
    send_frag(10'd7, 10'd7, 16'h0600, 64'h2, 1'b0, 1'b1, 1'b1, Z_LEQUAL, acc, rdy);
    wait_idle();
    check("b2b_reads",  64'(rd_q.size()), 64'd2);
    check("b2b_writes", 64'(wr_q.size()), 64'd1);
    check("b2b_outs",   64'(out_q.size()), 64'd1);
    if (rd_q.size() == 2 && wr_q.size() >= 1)
      check("b2b_rd2_after_wr", {63'd0, rd_q[1] > wr_q[0]}, 64'd1);
    check("b2b_stall_len", 64'(wr_q.size() > 0 && rd_q.size() > 0 ? wr_q[0] - rd_q[0] : 0), 64'd6);
    check("b2b_zmem", 64'(zmem[4487]), 64'h0400);
    check("b2b_cnt_z", 64'(cnt_z_kill), 64'd6);
    wr_stall = 0;

    // Reset while waiting for read data; the late strobe must be ignored.
    zmem[5769] = 16'h9000;
    rd_lat = 5;
    clear_logs();
    send_frag(10'd9, 10'd9, 16'h1000, 64'h3, 1'b0, 1'b1, 1'b1, Z_LESS, acc, rdy);
    for (int n = 0; n < 50 && rd_q.size() == 0; n++) begin @(posedge clk); #2; end
    check("rstmid_read_seen", 64'(rd_q.size()), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    check("rstmid_in_ready",  {63'd0, in_ready},  64'd1);
    check("rstmid_rd_req",    {63'd0, zb_rd_req}, 64'd0);
    check("rstmid_wr_req",    {63'd0, zb_wr_req}, 64'd0);
    check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstmid_cnt_z",     64'(cnt_z_kill), 64'd0);
    repeat (8) @(posedge clk);
    #2;
    check("rstmid_no_write", 64'(wr_q.size()), 64'd0);
    check("rstmid_no_out",   64'(out_q.size()), 64'd0);
    check("rstmid_zmem",     64'(zmem[5769]), 64'h9000);
    check("rstmid_idle",     {63'd0, in_ready}, 64'd1);

    rd_lat = 1;
    zmem[1285] = 16'h1000;
    clear_logs();
    send_frag(10'd5, 10'd2, 16'h0800, 64'h4, 1'b0, 1'b1, 1'b1, Z_LESS, acc, rdy);
    wait_idle();
    check("post_rst_outs",    64'(out_q.size()), 64'd1);
    check("post_rst_wr_data", 64'(zmem[1285]), 64'h0800);
    check("post_rst_latency", 64'(out_q.size() > 0 ? out_q[0] - acc : 0), 64'd4);
    check("post_rst_cnt_z",   64'(cnt_z_kill), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
